onehot_sequencer: RTL and testbench

Registered, handshaked successor to the combinational binary-to-one-hot decoder, used to drive per-channel enables, such as electrode/channel gating and comparator-node selects, in the spike-classification datapath. It accepts an encoded index with valid/ready, drives a registered one-hot word for a programmable dwell time, and optionally sweeps all channels round-robin from a start index. It supports non-power-of-two channel counts, with explicit out-of-range detection.

---
 rtl/onehot_pkg.sv | 15 +
 rtl/onehot_sequencer_if.sv | 28 ++
 rtl/onehot_sequencer_dec.sv | 20 ++
 rtl/onehot_sequencer.sv | 127 ++++++++++++
 tb/tb_onehot_sequencer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/onehot_pkg.sv
// Shared types for the one-hot decoder family.
// State encoding and index-width helper.
package onehot_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SWEEP
  } state_t;

  function automatic int log_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/onehot_sequencer_if.sv
// Request handshake for onehot_sequencer.
// Index, mode and dwell travel with valid/ready.
interface onehot_sequencer_if
  import onehot_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DWELL_BITS = 8
) ();

  localparam int LOG_WIDTH = log_w(WIDTH);

  logic                  in_valid;
  logic                  in_ready;
  logic [LOG_WIDTH-1:0]  encoded;
  logic                  scan;
  logic [DWELL_BITS-1:0] dwell;

  modport master (
    output in_valid, encoded, scan, dwell,
    input  in_ready
  );

  modport slave (
    input  in_valid, encoded, scan, dwell,
    output in_ready
  );

endinterface

// File: rtl/onehot_sequencer_dec.sv
// Combinational binary-to-one-hot decoder.
// Out-of-range or disabled index yields all-zero.
module onehot_sequencer_dec #(
  parameter int WIDTH     = 16,
  parameter int LOG_WIDTH = 4
) (
  input  logic                 en,
  input  logic [LOG_WIDTH-1:0] idx,
  output logic [WIDTH-1:0]     one_hot
);

  // One bit per channel, at most one can match.
  always_comb begin
    one_hot = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (en && (idx == LOG_WIDTH'(i))) one_hot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/onehot_sequencer.sv
// Handshaked one-hot channel sequencer.
// Direct hold or round-robin sweep with dwell.
module onehot_sequencer
  import onehot_pkg::*;
#(
  parameter  int WIDTH      = 16,
  parameter  int DWELL_BITS = 8,
  localparam int LOG_WIDTH  = log_w(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  onehot_sequencer_if.slave    req,
  output logic [WIDTH-1:0]     one_hot,
  output logic [LOG_WIDTH-1:0] index,
  output logic                 active,
  output logic                 wrap,
  output logic                 done,
  output logic                 err
);

  localparam int LW1 = LOG_WIDTH + 1;
  localparam logic [LOG_WIDTH-1:0] LAST =
    LOG_WIDTH'(WIDTH - 1);
  localparam logic [LOG_WIDTH-1:0] ONE_I =
    LOG_WIDTH'(1);
  localparam logic [DWELL_BITS-1:0] ONE_D =
    DWELL_BITS'(1);

  state_t                state_q, state_d;
  logic [DWELL_BITS-1:0] cnt_q, cnt_d;
  logic [DWELL_BITS-1:0] dwell_q, dwell_d;
  logic [LOG_WIDTH-1:0]  idx_q, idx_d;
  logic [LOG_WIDTH-1:0]  left_q, left_d;
  logic                  act_q, act_d;
  logic                  wrap_q, wrap_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  idle, fin, acc, oor;

  // left_q counts channels still to come after the current one.
  assign idle = (state_q == IDLE);
  assign fin  = (cnt_q == '0) && (left_q == '0);
  assign req.in_ready = idle || fin;
  assign acc  = req.in_valid && req.in_ready;
  assign oor  = {1'b0, req.encoded} >= LW1'(WIDTH);

  // Next state: advance the running request, then overlay an accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    idx_d   = idx_q;
    left_d  = left_q;
    act_d   = act_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    unique case (1'b1)
      idle: state_d = IDLE;
      !idle && (cnt_q != '0): cnt_d = cnt_q - ONE_D;
      !idle && (cnt_q == '0) && (left_q != '0): begin
        idx_d  = (idx_q == LAST) ? '0 : idx_q + ONE_I;
        wrap_d = (idx_q == LAST);
        cnt_d  = dwell_q;
        left_d = left_q - ONE_I;
      end
      !idle && fin: begin
        state_d = IDLE;
        act_d   = 1'b0;
        idx_d   = '0;
        cnt_d   = '0;
        left_d  = '0;
      end
    endcase
    if (acc && oor) err_d = 1'b1;
    if (acc && !oor) begin
      state_d = req.scan ? SWEEP : HOLD;
      idx_d   = req.encoded;
      cnt_d   = req.dwell;
      dwell_d = req.dwell;
      left_d  = req.scan ? LAST : '0;
      act_d   = 1'b1;
      wrap_d  = 1'b0;
    end
    done_d = act_d && (cnt_d == '0) && (left_d == '0);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dwell_q <= '0;
      idx_q   <= '0;
      left_q  <= '0;
      act_q   <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      idx_q   <= idx_d;
      left_q  <= left_d;
      act_q   <= act_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign index  = idx_q;
  assign active = act_q;
  assign wrap   = wrap_q;
  assign done   = done_q;
  assign err    = err_q;

  onehot_sequencer_dec #(
    .WIDTH     (WIDTH),
    .LOG_WIDTH (LOG_WIDTH)
  ) u_dec (
    .en      (act_q),
    .idx     (idx_q),
    .one_hot (one_hot)
  );

endmodule

// File: tb/tb_onehot_sequencer.sv
// Scoreboard bench for onehot_sequencer.
// Three widths: 16, 12 and 2 channels.
module tb_onehot_sequencer;

  typedef struct packed {
    logic [15:0] oh;
    logic [3:0]  idx;
    logic        wrap;
    logic        done;
    logic        err;
    logic        rdy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  bit   mon_en;
  int   checks = 0;
  int   errors = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  always #5 clk = ~clk;

  onehot_sequencer_if #(.WIDTH(16), .DWELL_BITS(8)) ifa ();
  onehot_sequencer_if #(.WIDTH(12), .DWELL_BITS(8)) ifb ();
  onehot_sequencer_if #(.WIDTH(2),  .DWELL_BITS(8)) ifc ();

  logic [15:0] a_oh;
  logic [3:0]  a_idx;
  logic        a_act, a_wrap, a_done, a_err;
  logic [11:0] b_oh;
  logic [3:0]  b_idx;
  logic        b_act, b_wrap, b_done, b_err;
  logic [1:0]  c_oh;
  logic [0:0]  c_idx;
  logic        c_act, c_wrap, c_done, c_err;

  onehot_sequencer #(.WIDTH(16), .DWELL_BITS(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(ifa),
    .one_hot(a_oh), .index(a_idx), .active(a_act),
    .wrap(a_wrap), .done(a_done), .err(a_err)
  );

  onehot_sequencer #(.WIDTH(12), .DWELL_BITS(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(ifb),
    .one_hot(b_oh), .index(b_idx), .active(b_act),
    .wrap(b_wrap), .done(b_done), .err(b_err)
  );

  onehot_sequencer #(.WIDTH(2), .DWELL_BITS(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .req(ifc),
    .one_hot(c_oh), .index(c_idx), .active(c_act),
    .wrap(c_wrap), .done(c_done), .err(c_err)
  );

  function automatic exp_t mk(input int bitn, input int idx,
                              input bit w, input bit d,
                              input bit e, input bit r);
    exp_t x;
    x.oh   = (bitn < 0) ? 16'h0 : (16'h1 << bitn);
    x.idx  = 4'(idx);
    x.wrap = w;
    x.done = d;
    x.err  = e;
    x.rdy  = r;
    return x;
  endfunction

  task automatic push_dir(ref exp_t q[$], input int e, input int d);
    for (int k = 0; k <= d; k++)
      q.push_back(mk(e, e, 1'b0, k == d, 1'b0, k == d));
  endtask

  task automatic push_swp(ref exp_t q[$], input int w,
                          input int s, input int d);
    int ix;
    bit last;
    ix = s;
    for (int ch = 0; ch < w; ch++) begin
      for (int k = 0; k <= d; k++) begin
        last = (ch == w - 1) && (k == d);
        q.push_back(mk(ix, ix, (ch > 0) && (ix == 0) && (k == 0),
                       last, 1'b0, last));
      end
      ix = (ix + 1) % w;
    end
  endtask

  task automatic push_err(ref exp_t q[$]);
    q.push_back(mk(-1, 0, 1'b0, 1'b0, 1'b1, 1'b1));
  endtask

  task automatic pop_cmp(ref exp_t q[$], input string nm,
                         input exp_t got);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected output got %h want none", nm, got);
    end else begin
      e = q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL %s got oh=%h idx=%0d wrap=%b done=%b err=%b rdy=%b want oh=%h idx=%0d wrap=%b done=%b err=%b rdy=%b",
                 nm, got.oh, got.idx, got.wrap, got.done, got.err, got.rdy,
                 e.oh, e.idx, e.wrap, e.done, e.err, e.rdy);
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mon_en && (a_act || a_err))
      pop_cmp(qa, "w16", {a_oh, a_idx, a_wrap, a_done, a_err,
                          ifa.in_ready});
    if (rst_n && mon_en && (b_act || b_err))
      pop_cmp(qb, "w12", {4'h0, b_oh, b_idx, b_wrap, b_done, b_err,
                          ifb.in_ready});
    if (rst_n && mon_en && (c_act || c_err))
      pop_cmp(qc, "w2", {14'h0, c_oh, 3'h0, c_idx, c_wrap, c_done,
                         c_err, ifc.in_ready});
  end

  function automatic bit get_rdy(input int w);
    case (w)
      0:       return ifa.in_ready;
      1:       return ifb.in_ready;
      default: return ifc.in_ready;
    endcase
  endfunction

  task automatic send(input int w, input int e, input bit s,
                      input int d);
    int n;
    bit rdy;
    n = 0;
    @(negedge clk);
    case (w)
      0: begin
        ifa.in_valid = 1'b1; ifa.encoded = 4'(e);
        ifa.scan = s; ifa.dwell = 8'(d);
      end
      1: begin
        ifb.in_valid = 1'b1; ifb.encoded = 4'(e);
        ifb.scan = s; ifb.dwell = 8'(d);
      end
      default: begin
        ifc.in_valid = 1'b1; ifc.encoded = 1'(e);
        ifc.scan = s; ifc.dwell = 8'(d);
      end
    endcase
    rdy = get_rdy(w);
    while (!rdy && n < 2000) begin
      @(negedge clk);
      n++;
      rdy = get_rdy(w);
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got ready=0 want ready=1 dut=%0d", w);
    end
    @(posedge clk);
    #1;
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;
    ifc.in_valid = 1'b0;
  endtask

  initial begin
    int n, e, d, hits;
    bit s;
    ifa.in_valid = 0; ifa.encoded = 0; ifa.scan = 0; ifa.dwell = 0;
    ifb.in_valid = 0; ifb.encoded = 0; ifb.scan = 0; ifb.dwell = 0;
    ifc.in_valid = 0; ifc.encoded = 0; ifc.scan = 0; ifc.dwell = 0;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #12;
    chk("rst_one_hot", int'(a_oh), 0);
    chk("rst_index", int'(a_idx), 0);
    chk("rst_active", int'(a_act), 0);
    chk("rst_wrap", int'(a_wrap), 0);
    chk("rst_done", int'(a_done), 0);
    chk("rst_err", int'(a_err), 0);
    chk("rst_ready", int'(ifa.in_ready), 1);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    push_dir(qa, 5, 2);
    send(0, 5, 1'b0, 2);
    push_swp(qa, 16, 14, 0);
    send(0, 14, 1'b1, 0);
    push_dir(qa, 3, 1);
    push_dir(qa, 9, 0);
    send(0, 3, 1'b0, 1);
    send(0, 9, 1'b0, 0);

    push_err(qb);
    send(1, 13, 1'b0, 0);
    push_dir(qb, 2, 1);
    push_err(qb);
    send(1, 2, 1'b0, 1);
    send(1, 15, 1'b0, 0);
    push_dir(qb, 11, 0);
    send(1, 11, 1'b0, 0);
    push_swp(qb, 12, 11, 0);
    send(1, 11, 1'b1, 0);

    push_swp(qc, 2, 1, 0);
    send(2, 1, 1'b1, 0);
    push_swp(qc, 2, 0, 1);
    send(2, 0, 1'b1, 1);

    for (int r = 0; r < 300; r++) begin
      e = $urandom_range(0, 15);
      d = $urandom_range(0, 3);
      s = ($urandom_range(0, 7) == 0);
      if (s) push_swp(qa, 16, e, d);
      else   push_dir(qa, e, d);
      send(0, e, s, d);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    n = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_left", qa.size() + qb.size() + qc.size(), 0);

    mon_en = 1'b0;
    send(0, 4, 1'b1, 3);
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_one_hot", int'(a_oh), 0);
    chk("async_ready", int'(ifa.in_ready), 1);
    chk("async_active", int'(a_act), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (a_done || a_act) hits++;
    end
    chk("post_reset_quiet", hits, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
